// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and parcel-assembly helpers for the
// direct-mapped instruction cache.
package icache_pkg;

    localparam int DEFAULT_INDEX_BITS = 6;

    // Low two bits of a halfword that mark a full 32-bit (non-compressed) instruction.
    localparam logic [1:0] FULL_LEN_BITS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL_A,
        ST_FILL_B,
        ST_RESP
    } state_e;

    // True when a halfword-aligned fetch starts a 32-bit instruction and so
    // spills into the following word.
    function automatic logic needs_word_b(input logic i_pc1, input logic [31:0] i_word_a);
        return i_pc1 && (i_word_a[17:16] == FULL_LEN_BITS);
    endfunction

    function automatic logic [31:0] assemble_parcel(input logic i_pc1,
                                                    input logic [31:0] i_word_a,
                                                    input logic [31:0] i_word_b);
        if (!i_pc1)
            return i_word_a;
        else if (needs_word_b(i_pc1, i_word_a))
            return {i_word_b[15:0], i_word_a[31:16]};
        else
            return {16'h0000, i_word_a[31:16]};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response and memory-side refill signals of the icache.
interface icache_if;

    logic        to_icache;
    logic [31:0] pc_to_icache;
    logic        have_result;
    logic [31:0] inst_from_icache;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    // The cache itself.
    modport slave (
        input  to_icache, pc_to_icache, mem_valid, mem_data,
        output have_result, inst_from_icache, mem_req, mem_addr
    );

    // Fetch stage plus memory controller.
    modport master (
        output to_icache, pc_to_icache, mem_valid, mem_data,
        input  have_result, inst_from_icache, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: two combinational lookup ports and one synchronous
// refill write port; only the valid bits are cleared by reset.
module icache_array
    import icache_pkg::*;
#(
    parameter  int INDEX_BITS = DEFAULT_INDEX_BITS,
    localparam int TAG_BITS   = 30 - INDEX_BITS,
    localparam int ENTRIES    = 1 << INDEX_BITS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] i_idx_a,
    input  logic [TAG_BITS-1:0]   i_tag_a,
    output logic                  o_hit_a,
    output logic [31:0]           o_data_a,
    input  logic [INDEX_BITS-1:0] i_idx_b,
    input  logic [TAG_BITS-1:0]   i_tag_b,
    output logic                  o_hit_b,
    output logic [31:0]           o_data_b,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_w_idx,
    input  logic [TAG_BITS-1:0]   i_w_tag,
    input  logic [31:0]           i_w_data
);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_BITS-1:0] r_tag  [ENTRIES];
    logic [31:0]         r_data [ENTRIES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_w_idx] <= 1'b1;
    end

    // NOTE: tag/data arrays carry no reset; the cleared valid bit masks
    // whatever they hold, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk_in) begin
        if (i_we) begin
            r_tag[i_w_idx]  <= i_w_tag;
            r_data[i_w_idx] <= i_w_data;
        end
    end

    assign o_hit_a  = r_valid[i_idx_a] && (r_tag[i_idx_a] == i_tag_a);
    assign o_data_a = r_data[i_idx_a];
    assign o_hit_b  = r_valid[i_idx_b] && (r_tag[i_idx_b] == i_tag_b);
    assign o_data_b = r_data[i_idx_b];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: FSM, address split, parcel assembly and
// one-word-per-transaction refill handshake with the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    state_e      r_state;
    logic [31:1] r_pc;
    logic        r_have_result;
    logic [31:0] r_inst;
    logic        r_mem_req;
    logic [29:0] r_fill_word;

    logic [29:0] w_word_a;
    logic [29:0] w_word_b;
    logic        w_hit_a;
    logic        w_hit_b;
    logic [31:0] w_data_a;
    logic [31:0] w_data_b;
    logic        w_need_b;
    logic        w_fill_done;
    logic        w_unused_pc0;

    // Word B wraps naturally in 30 bits, so the last word pairs with word 0.
    assign w_word_a     = r_pc[31:2];
    assign w_word_b     = w_word_a + 30'd1;
    assign w_need_b     = needs_word_b(r_pc[1], w_data_a);
    assign w_fill_done  = rdy_in && bus.mem_valid &&
                          (r_state == ST_FILL_A || r_state == ST_FILL_B);
    assign w_unused_pc0 = bus.pc_to_icache[0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_idx_a  (w_word_a[INDEX_BITS-1:0]),
        .i_tag_a  (w_word_a[29:INDEX_BITS]),
        .o_hit_a  (w_hit_a),
        .o_data_a (w_data_a),
        .i_idx_b  (w_word_b[INDEX_BITS-1:0]),
        .i_tag_b  (w_word_b[29:INDEX_BITS]),
        .o_hit_b  (w_hit_b),
        .o_data_b (w_data_b),
        .i_we     (w_fill_done),
        .i_w_idx  (r_fill_word[INDEX_BITS-1:0]),
        .i_w_tag  (r_fill_word[29:INDEX_BITS]),
        .i_w_data (bus.mem_data)
    );

    // Every fill returns to LOOKUP so the hit/RVC decision is always made
    // against the array contents, including the word just written.
    // NOTE: all state here is assigned with <= so every branch sees the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_have_result <= 1'b0;
            r_inst        <= '0;
            r_mem_req     <= 1'b0;
            r_fill_word   <= '0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.to_icache) begin
                        r_pc    <= bus.pc_to_icache[31:1];
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!w_hit_a) begin
                        r_mem_req   <= 1'b1;
                        r_fill_word <= w_word_a;
                        r_state     <= ST_FILL_A;
                    end else if (w_need_b && !w_hit_b) begin
                        r_mem_req   <= 1'b1;
                        r_fill_word <= w_word_b;
                        r_state     <= ST_FILL_B;
                    end else begin
                        r_have_result <= 1'b1;
                        r_inst        <= assemble_parcel(r_pc[1], w_data_a, w_data_b);
                        r_state       <= ST_RESP;
                    end
                end
                ST_FILL_A, ST_FILL_B: begin
                    if (bus.mem_valid) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_RESP: begin
                    r_have_result <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.have_result      = r_have_result;
    assign bus.inst_from_icache = r_inst;
    assign bus.mem_req          = r_mem_req;
    assign bus.mem_addr         = {r_fill_word, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written pause
// and reset sequences, then random fetches against a behavioural cache model.
module tb_icache;

    localparam int IB = 6;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    icache_if bus ();

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_tests;
    int n_fail;

    // Memory controller model.
    logic [31:0] mem_img [logic [29:0]];
    logic [31:0] addr_log [$];
    int          mem_lat;
    int          lat_cnt;
    bit          mem_auto;
    bit          inject_stray;
    logic        rdy_at_pos;

    // Behavioural cache model.
    logic        m_valid [1 << IB];
    logic [29-IB:0] m_tag [1 << IB];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] parcel;
        int          fills;
        logic [31:0] a0;
        logic [31:0] a1;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (mem_img.exists(w))
            return mem_img[w];
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk_in) rdy_at_pos <= rdy_in;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        lat_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (bus.mem_valid) begin
                if (rdy_at_pos || !rst_in) bus.mem_valid = 1'b0;
            end else if (inject_stray) begin
                inject_stray  = 1'b0;
                bus.mem_valid = 1'b1;
                bus.mem_data  = 32'hDEAD_BEEF;
            end else if (mem_auto && rst_in && bus.mem_req) begin
                if (lat_cnt >= mem_lat) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = mem_word(bus.mem_addr[31:2]);
                    addr_log.push_back(bus.mem_addr);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    function automatic bit model_has(input logic [29:0] w);
        return m_valid[w[IB-1:0]] && (m_tag[w[IB-1:0]] == w[29:IB]);
    endfunction

    task automatic model_install(input logic [29:0] w);
        m_valid[w[IB-1:0]] = 1'b1;
        m_tag[w[IB-1:0]]   = w[29:IB];
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1 << IB); i++) m_valid[i] = 1'b0;
    endtask

    // Addresses refilled are packed {first, second}; the parcel comes from the memory image.
    task automatic model_fetch(input logic [31:0] pc, output logic [31:0] parcel,
                               output int n, output logic [63:0] addrs);
        logic [29:0] wa;
        logic [29:0] wb;
        logic [31:0] da;
        logic [31:0] db;
        wa = pc[31:2];
        wb = wa + 30'd1;
        n = 0;
        addrs = '0;
        if (!model_has(wa)) begin
            addrs[63:32] = {wa, 2'b00};
            n = 1;
            model_install(wa);
        end
        da = mem_word(wa);
        if (!pc[1]) begin
            parcel = da;
        end else if (da[17:16] != 2'b11) begin
            parcel = {16'h0000, da[31:16]};
        end else begin
            if (!model_has(wb)) begin
                if (n == 0) addrs[63:32] = {wb, 2'b00};
                else        addrs[31:0]  = {wb, 2'b00};
                n++;
                model_install(wb);
            end
            db = mem_word(wb);
            parcel = {db[15:0], da[31:16]};
        end
    endtask

    // Issues one request pulse; lat counts edges from the request edge to the
    // first edge after which have_result is seen high (-1 on timeout).
    task automatic run_fetch(input logic [31:0] pc, output logic [31:0] parcel,
                             output int lat, output int width);
        @(negedge clk_in);
        addr_log.delete();
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = pc;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.to_icache = 1'b0;
        lat = -1;
        parcel = '0;
        width = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk_in);
            #1;
            if (bus.have_result) begin
                lat = c;
                parcel = bus.inst_from_icache;
                break;
            end
        end
        if (lat > 0) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.have_result) break;
                width++;
                @(posedge clk_in);
                #1;
            end
        end
    endtask

    function automatic logic [63:0] logged_addrs();
        logic [63:0] r;
        r = '0;
        if (addr_log.size() > 0) r[63:32] = addr_log[0];
        if (addr_log.size() > 1) r[31:0]  = addr_log[1];
        return r;
    endfunction

    task automatic model_checked_fetch(input logic [31:0] pc, input string tag);
        logic [31:0] exp_parcel;
        logic [31:0] got_parcel;
        logic [63:0] exp_addrs;
        int          n;
        int          lat;
        int          width;
        model_fetch(pc, exp_parcel, n, exp_addrs);
        run_fetch(pc, got_parcel, lat, width);
        check($sformatf("%s parcel pc=%h", tag, pc), got_parcel, exp_parcel);
        check($sformatf("%s latency pc=%h", tag, pc), lat, 1 + n * (2 + mem_lat));
        check($sformatf("%s refill count pc=%h", tag, pc), addr_log.size(), n);
        check($sformatf("%s refill addrs pc=%h", tag, pc), logged_addrs(), exp_addrs);
        check($sformatf("%s pulse width pc=%h", tag, pc), width, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] parcel;
        logic [31:0] pc;
        int          lat;
        int          width;
        int          cnt;
        bit          held_ok;

        n_tests = 0;
        n_fail  = 0;
        mem_lat = 0;
        mem_auto = 1'b1;
        inject_stray = 1'b0;
        model_clear();

        mem_img[30'h0000_0400] = 32'h0051_0113;
        mem_img[30'h0000_0C00] = 32'h0093_0013;
        mem_img[30'h0000_0C01] = 32'hABCD_0000;
        mem_img[30'h0000_0800] = 32'h4505_0000;
        mem_img[30'h0000_0040] = 32'h1111_0100;
        mem_img[30'h0000_0080] = 32'h2222_0200;
        mem_img[30'h3FFF_FFFF] = 32'h7777_0000;
        mem_img[30'h0000_0000] = 32'h0000_5555;

        tbl[0]  = '{32'h0000_1000, 32'h0051_0113, 1, 32'h0000_1000, 32'h0, 3};
        tbl[1]  = '{32'h0000_1000, 32'h0051_0113, 0, 32'h0,         32'h0, 1};
        tbl[2]  = '{32'h0000_3002, 32'h0000_0093, 2, 32'h0000_3000, 32'h0000_3004, 5};
        tbl[3]  = '{32'h0000_3002, 32'h0000_0093, 0, 32'h0,         32'h0, 1};
        tbl[4]  = '{32'h0000_2002, 32'h0000_4505, 1, 32'h0000_2000, 32'h0, 3};
        tbl[5]  = '{32'h0000_0100, 32'h1111_0100, 1, 32'h0000_0100, 32'h0, 3};
        tbl[6]  = '{32'h0000_0200, 32'h2222_0200, 1, 32'h0000_0200, 32'h0, 3};
        tbl[7]  = '{32'h0000_0100, 32'h1111_0100, 1, 32'h0000_0100, 32'h0, 3};
        tbl[8]  = '{32'h0000_3002, 32'h0000_0093, 1, 32'h0000_3000, 32'h0, 3};
        tbl[9]  = '{32'h0000_1001, 32'h0051_0113, 1, 32'h0000_1000, 32'h0, 3};
        tbl[10] = '{32'hFFFF_FFFE, 32'h5555_7777, 2, 32'hFFFF_FFFC, 32'h0000_0000, 5};

        // Reset state.
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.to_icache    = 1'b0;
        bus.pc_to_icache = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset have_result", bus.have_result, 1'b0);
        check("reset inst", bus.inst_from_icache, 32'h0);
        check("reset mem_req", bus.mem_req, 1'b0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            run_fetch(tbl[i].pc, parcel, lat, width);
            check($sformatf("vec%0d parcel", i), parcel, tbl[i].parcel);
            check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
            check($sformatf("vec%0d pulse width", i), width, 1);
            check($sformatf("vec%0d refill count", i), addr_log.size(), tbl[i].fills);
            check($sformatf("vec%0d refill addrs", i), logged_addrs(), {tbl[i].a0, tbl[i].a1});
        end

        // Pause for three cycles while the response is being presented.
        @(negedge clk_in);
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = 32'hFFFF_FFFE;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.to_icache = 1'b0;
        @(posedge clk_in);
        #1;
        check("pause resp first cycle", bus.have_result, 1'b1);
        check("pause resp parcel", bus.inst_from_icache, 32'h5555_7777);
        @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("pause resp held %0d", i), bus.have_result, 1'b1);
        end
        @(negedge clk_in);
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("pause resp released", bus.have_result, 1'b0);

        // Pause while a refill is outstanding; data arriving in the pause must wait.
        mem_lat = 3;
        @(negedge clk_in);
        addr_log.delete();
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = 32'h0000_0600;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.to_icache = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        held_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in);
            #1;
            if (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h0000_0600)) held_ok = 1'b0;
        end
        check("pause fill req held", held_ok, 1'b1);
        check("pause fill data waiting", bus.mem_valid, 1'b1);
        @(negedge clk_in);
        rdy_in = 1'b1;
        cnt = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_in);
            #1;
            if (bus.have_result) begin
                cnt = c;
                break;
            end
        end
        check("pause fill resume latency", cnt, 2);
        check("pause fill parcel", bus.inst_from_icache, mem_word(30'h180));
        check("pause fill single refill", addr_log.size(), 1);
        @(posedge clk_in);
        #1;
        mem_lat = 0;

        // Reset in the middle of a refill, then a stray mem_valid.
        mem_auto = 1'b0;
        @(negedge clk_in);
        bus.to_icache    = 1'b1;
        bus.pc_to_icache = 32'h0000_0400;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.to_icache = 1'b0;
        @(posedge clk_in);
        #1;
        check("midfill mem_req", bus.mem_req, 1'b1);
        check("midfill mem_addr", bus.mem_addr, 32'h0000_0400);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("midfill async reset mem_req", bus.mem_req, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_clear();
        inject_stray = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.have_result !== 1'b0 || bus.mem_req !== 1'b0) held_ok = 1'b0;
        end
        check("stray mem_valid ignored", held_ok, 1'b1);
        mem_auto = 1'b1;
        model_checked_fetch(32'h0000_1000, "post-reset");
        model_checked_fetch(32'hFFFF_FFFE, "post-reset");
        model_checked_fetch(32'h0000_3002, "post-reset");

        // Random fetches against the model.
        for (int i = 0; i < 150; i++) begin
            mem_lat = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0)
                pc = 32'hFFFF_FFFE;
            else
                pc = ($urandom_range(0, 511) << 1) | $urandom_range(0, 1);
            model_checked_fetch(pc, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch stage and the memory controller. Accepts one fetch address at a time from the fetch stage, returns a 32-bit instruction parcel (including halfword-aligned and RVC instructions), and refills missing words from memory one word per transaction. Word-granular lines; a parcel straddling two words may need two refills.

## Interface
Parameters:
- `INDEX_BITS`, 6: log2 of entry count; one 32-bit word per entry; tag width = 30 − INDEX_BITS.

Ports:
- `clk_in`  in  1  clock, all state on rising edge.
- `rst_in`  in  1  reset; **asynchronous, active-low**.
- `rdy_in`  in  1  global pause when low; all state, counters and outputs hold.
- `to_icache`  in  1  request, sampled on a rising edge; one-cycle pulse from fetch.
- `pc_to_icache`  in  32  fetch address, bit 0 ignored (treated as 0).
- `have_result`  out  1  one-cycle pulse: `inst_from_icache` valid.
- `inst_from_icache`  out  32  instruction parcel; held until next `have_result`.
- `mem_req`  out  1  word read request, level, held until `mem_valid`.
- `mem_addr`  out  32  word-aligned address; bits [1:0] = 0.
- `mem_valid`  in  1  memory data valid for the current request (one cycle).
- `mem_data`  in  32  word read data.

## Operation
- Address split: word A = pc[31:2], index = A[INDEX_BITS-1:0], tag = A[29:INDEX_BITS]; word B = A + 1 (30-bit wrap: 0x3FFFFFFF + 1 = 0).
- Parcel assembly: pc[1]=0 → word A. pc[1]=1 → low half = A[31:16]; if A[17:16] ≠ 2'b11 (RVC) high half = 16'h0 and B not needed; else high half = B[15:0].
- States: IDLE, FILL_A, FILL_B, RESP.
- IDLE: on `to_icache`, latch pc. Needed words all hit → RESP with parcel. Else A misses → FILL_A; A hits, B needed and misses → FILL_B.
- FILL_A: `mem_req`=1, `mem_addr`={A,2'b00}. On `mem_valid`: write data/tag/valid for A; then B needed and missing (re-check after A written; same index as A only if INDEX_BITS=30, not supported) → FILL_B, else RESP. RVC decision uses the freshly filled A word.
- FILL_B: same for B; then RESP.
- RESP: `have_result`=1, `inst_from_icache`=parcel for one cycle; → IDLE.
- Requests arriving outside IDLE are ignored (no response). A request is always completed even if fetch has dropped interest (fetch discards it).
- Refill writes replace the entry unconditionally (no dirty state).
- Reset: all valid bits 0, state IDLE, `have_result`=0, `inst_from_icache`=0, `mem_req`=0, `mem_addr`=0. Reset mid-fill abandons the transaction; a late `mem_valid` in IDLE is ignored.

## Timing
- Hit: request at edge k → `have_result` high in cycle after edge k+1 (1-cycle latency), low after edge k+2.
- Miss on A only: `mem_req` asserted from edge k+1; `mem_valid` at edge m → `have_result` after edge m+1.
- Double miss: two back-to-back transactions; `mem_req` deasserts for one cycle between them is not required (may stay high with new `mem_addr` from edge m+1).
- `rdy_in`=0 freezes everything including `mem_req`/`mem_addr`; `mem_valid` during pause is not consumed (memory controller shares `rdy_in`).
- Earliest next request accepted: the edge after `have_result` drops (IDLE).

## Structure
- `const.v`: state encodings, default INDEX_BITS, RVC low-bits constant 2'b11.
- Sub-module `icache_array`: valid/tag/data storage, two combinational read ports (A, B), one synchronous write port, async active-low clear of valid bits.
- Top: FSM, address split, parcel assembly, memory handshake.

## Test plan
- Cold miss then hit: pc 0x0000_1000, `mem_data`=0x0051_0113 → parcel 0x0051_0113; repeat → `have_result` one cycle after request, no `mem_req`.
- Straddle 32-bit: pc 0x1002, words 0x1000=0x1234_0013 (hi=0x1234? make hi 0x0093), 0x1004=0xABCD_0000 → two fills, parcel {0x0000, hi of 0x1000 word}; check both addresses 0x1000, 0x1004 issued.
- RVC at pc[1]=1: word 0x2000=0x4505_0000 → single fill, parcel 0x0000_4505, no access to 0x2004.
- Conflict eviction: fill 0x0000_0100 then 0x0000_0200 with INDEX_BITS=6 (same index) → second re-read of 0x100 misses.
- Reset mid-FILL_A then stray `mem_valid` → no `have_result`, all lookups miss afterwards.
- `rdy_in` low for 3 cycles during RESP → `have_result` stays high, pulse ends one active cycle after `rdy_in` returns.
